// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, count limits and display-half widths for the stopwatch block.
// Pure definitions, no timing or flow control of its own.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int MAX_COUNT = 9999;
    localparam int COUNT_W   = 14;
    localparam int HALF_W    = 32;

    function automatic logic [COUNT_W-1:0] cnt_inc(input logic [COUNT_W-1:0] c);
        if (c >= COUNT_W'(MAX_COUNT)) begin
            return '0;
        end
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-cycle press pulse on a debounced rising edge.
// Latency: raw edge to o_press = 2 + DB_CYCLES + 1 cycles; no backpressure, pulses are fire-and-forget.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [1:0]    r_vld;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_armed;
    logic          r_press;
    logic          w_sync;

    assign w_sync  = r_sync[1];
    assign o_press = r_press;

    // r_armed stays low until the button has been seen released after reset,
    // so a button held through reset never produces a press.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync    <= '0;
            r_vld     <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_vld  <= {r_vld[0], 1'b1};
            if (r_vld[1] && !w_sync) begin
                r_armed <= 1'b1;
            end
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= w_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d & r_armed;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/pause/clear stopwatch with centisecond count; STOPWATCH_LAP_EN adds lap capture, else lower half is the pause snapshot.
// Latency: button edge to state 2+DB_CYCLES+2 cycles, din_h one cycle behind counts; no backpressure.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic        btn_clr,
    output logic [63:0] din_h,
    output logic        running
);

    import stopwatch_pkg::*;

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PAD_W = HALF_W - COUNT_W;

    logic               w_start_p;
    logic               w_clr_p;
    logic               w_tick;
    logic               w_enter_run;
    logic               w_pause;
    logic [COUNT_W-1:0] w_run_cnt_nxt;
    state_e             w_state_nxt;

    state_e             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [COUNT_W-1:0] r_run_cnt;
    logic [COUNT_W-1:0] r_lo_cnt;
    logic [63:0]        r_din;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_btn   (btn_start),
        .o_press (w_start_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_btn   (btn_clr),
        .o_press (w_clr_p)
    );

`ifdef STOPWATCH_LAP_EN
    logic w_lap_p;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_btn   (btn_lap),
        .o_press (w_lap_p)
    );
`else
    logic w_unused_lap;
    assign w_unused_lap = btn_lap;
`endif

    assign w_tick      = (r_state == RUN) && (r_div == DIV_W'(DIV - 1));
    assign w_enter_run = w_start_p && !w_clr_p && (r_state != RUN);
    assign w_pause     = w_start_p && !w_clr_p && (r_state == RUN);

    // A tick coinciding with the pause still lands in the frozen count.
    assign w_run_cnt_nxt = w_clr_p ? '0 : (w_tick ? cnt_inc(r_run_cnt) : r_run_cnt);

    always_comb begin
        w_state_nxt = r_state;
        if (w_clr_p) begin
            w_state_nxt = IDLE;
        end else if (w_enter_run) begin
            w_state_nxt = RUN;
        end else if (w_pause) begin
            w_state_nxt = PAUSE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_run_cnt <= '0;
            r_lo_cnt  <= '0;
            r_din     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_cnt_nxt;
            if (w_clr_p || w_enter_run) begin
                r_div <= '0;
            end else if (r_state == RUN) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
            end
            if (w_clr_p) begin
                r_lo_cnt <= '0;
`ifdef STOPWATCH_LAP_EN
            end else if (w_lap_p && (r_state != IDLE)) begin
                r_lo_cnt <= r_run_cnt;
`else
            end else if (w_pause) begin
                r_lo_cnt <= w_run_cnt_nxt;
`endif
            end
            r_din <= {{PAD_W{1'b0}}, r_run_cnt, {PAD_W{1'b0}}, r_lo_cnt};
        end
    end

    assign din_h   = r_din;
    assign running = (r_state == RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table plus hand-written corner sequences for stopwatch_ctrl at 10 cycles/tick, DB_CYCLES=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    localparam int OP_WAIT    = 0;
    localparam int OP_PRESS   = 1;
    localparam int OP_PRELOAD = 2;
    localparam int NV         = 19;
    localparam int B_START    = 1;
    localparam int B_LAP      = 2;
    localparam int B_CLR      = 4;

    typedef struct {
        int   op;
        int   arg;
        logic exp_run;
        int   exp_hi;
        int   exp_lo;
    } vec_t;

    typedef struct {
        logic run;
        int   hi;
        int   lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clr = 1'b0;
    logic [63:0] din_h;
    logic        running;

    vec_t vecs[NV];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    stopwatch_ctrl #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .btn_clr   (btn_clr),
        .din_h     (din_h),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int m);
        btn_start = m[0];
        btn_lap   = m[1];
        btn_clr   = m[2];
        step(8);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clr   = 1'b0;
    endtask

    initial begin : main
        exp_t e;
        logic [5:0] bounce;

        // Offsets in comments are falling edges after the first RUN entry.
        vecs[0]  = '{OP_WAIT,    105,  1'b1, 10,   0};                // 105
        vecs[1]  = '{OP_WAIT,    140,  1'b1, 24,   0};                // 245
        vecs[2]  = '{OP_PRESS,   B_LAP, 1'b1, 25,  0};                // 253, lap not yet on din_h
        vecs[3]  = '{OP_WAIT,    2,    1'b1, 25,   LAP ? 25 : 0};     // 255
        vecs[4]  = '{OP_WAIT,    20,   1'b1, 27,   LAP ? 25 : 0};     // 275
        vecs[5]  = '{OP_WAIT,    117,  1'b1, 39,   LAP ? 25 : 0};     // 392
        vecs[6]  = '{OP_PRESS,   B_START | B_LAP, 1'b0, 39, LAP ? 25 : 0}; // pause edge 400 has a tick
        vecs[7]  = '{OP_WAIT,    2,    1'b0, 40,   LAP ? 39 : 40};    // lap used pre-edge count
        vecs[8]  = '{OP_WAIT,    20,   1'b0, 40,   LAP ? 39 : 40};
        vecs[9]  = '{OP_PRESS,   B_LAP, 1'b0, 40,  LAP ? 39 : 40};
        vecs[10] = '{OP_WAIT,    2,    1'b0, 40,   40};
        vecs[11] = '{OP_PRELOAD, 9998, 1'b0, 9998, 40};
        vecs[12] = '{OP_PRESS,   B_START, 1'b1, 9998, 40};            // second RUN entry R2
        vecs[13] = '{OP_WAIT,    15,   1'b1, 9999, 40};
        vecs[14] = '{OP_WAIT,    10,   1'b1, 0,    40};
        vecs[15] = '{OP_PRESS,   B_START | B_CLR, 1'b0, 1, 40};       // clr wins over start
        vecs[16] = '{OP_WAIT,    2,    1'b0, 0,    0};
        vecs[17] = '{OP_PRESS,   B_LAP, 1'b0, 0,   0};
        vecs[18] = '{OP_WAIT,    5,    1'b0, 0,    0};

        step(3);
        check("reset_running", {63'b0, running}, 64'd0);
        check("reset_din", din_h, 64'd0);
        rstn = 1'b1;
        step(5);

        btn_start = 1'b1;
        step(7);
        check("start_lat7", {63'b0, running}, 64'd0);
        step(1);
        check("start_lat8", {63'b0, running}, 64'd1);
        btn_start = 1'b0;

        for (int i = 0; i < NV; i++) begin
            sb.push_back('{vecs[i].exp_run, vecs[i].exp_hi, vecs[i].exp_lo});
            case (vecs[i].op)
                OP_WAIT:  step(vecs[i].arg);
                OP_PRESS: press(vecs[i].arg);
                default: begin
                    force dut.w_run_cnt_nxt = 14'd9998;
                    step(1);
                    release dut.w_run_cnt_nxt;
                    step(1);
                end
            endcase
            e = sb.pop_front();
            check($sformatf("v%0d_running", i), {63'b0, running}, {63'b0, e.run});
            check($sformatf("v%0d_hi", i), {32'b0, din_h[63:32]}, 64'(e.hi));
            check($sformatf("v%0d_lo", i), {32'b0, din_h[31:0]}, 64'(e.lo));
        end

        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(20);
        check("glitch_rejected", {63'b0, running}, 64'd0);

        bounce = 6'b111101;
        for (int i = 0; i < 12; i++) begin
            btn_start = (i < 6) ? bounce[i] : 1'b1;
            step(1);
        end
        btn_start = 1'b0;
        step(20);
        check("bounce_one_press", {63'b0, running}, 64'd1);
        check("bounce_counting", {63'b0, din_h[31:0]}, 64'd0);

        rstn = 1'b0;
        #1;
        check("async_rst_din", din_h, 64'd0);
        check("async_rst_running", {63'b0, running}, 64'd0);

        btn_start = 1'b1;
        step(2);
        rstn = 1'b1;
        step(20);
        check("held_through_reset", {63'b0, running}, 64'd0);
        btn_start = 1'b0;
        step(10);
        press(B_START);
        check("repress_after_reset", {63'b0, running}, 64'd1);
        step(2);
        check("repress_din_hi", {32'b0, din_h[63:32]}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
